// File: rtl/regfile_wb_port.sv
// Integer register file: MEM/WB write-back sink and two ID-stage read ports.
// After reset the array is swept to zero one entry per cycle while a stall is held.
module regfile_wb_port #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg_write_addr_i,
  input  logic              reg_write_en_i,
  input  logic [DATA_W-1:0] reg_write_data_i,
  input  logic              reg1_read_en_i,
  input  logic [ADDR_W-1:0] reg1_read_addr_i,
  output logic [DATA_W-1:0] reg1_data_o,
  input  logic              reg2_read_en_i,
  input  logic [ADDR_W-1:0] reg2_read_addr_i,
  output logic [DATA_W-1:0] reg2_data_o,
  output logic              stall_req_o,
  output logic              init_done_o
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] sweep_cnt_q;
  logic [ADDR_W-1:0] sweep_cnt_d;
  logic              stall_q;
  logic              init_done_q;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  always_comb begin
    sweep_cnt_d = sweep_cnt_q + ADDR_W'(1);
  end

  // Array is deliberately left out of reset; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_cnt_q <= ADDR_W'(1);
      stall_q     <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          mem_q[sweep_cnt_q] <= '0;
          sweep_cnt_q        <= sweep_cnt_d;
          if (sweep_cnt_q == LAST_IDX) begin
            state_q     <= RUN;
            stall_q     <= 1'b0;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (reg_write_en_i && (reg_write_addr_i != '0)) begin
            mem_q[reg_write_addr_i] <= reg_write_data_i;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              run,
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (run && en && (addr != '0)) begin
      if (wen && (waddr == addr)) r = wdata;
      else                        r = stored;
    end
    return r;
  endfunction

  always_comb begin
    reg1_data_o = read_port(state_q == RUN, reg1_read_en_i, reg1_read_addr_i,
                            reg_write_en_i, reg_write_addr_i, reg_write_data_i,
                            mem_q[reg1_read_addr_i]);
    reg2_data_o = read_port(state_q == RUN, reg2_read_en_i, reg2_read_addr_i,
                            reg_write_en_i, reg_write_addr_i, reg_write_data_i,
                            mem_q[reg2_read_addr_i]);
  end

  assign stall_req_o = stall_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_regfile_wb_port.sv
// Directed bench for regfile_wb_port: reset sweep, bypass, r0, read enables, resets.
module tb_regfile_wb_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg_write_addr_i;
  logic        reg_write_en_i;
  logic [31:0] reg_write_data_i;
  logic        reg1_read_en_i;
  logic [4:0]  reg1_read_addr_i;
  logic [31:0] reg1_data_o;
  logic        reg2_read_en_i;
  logic [4:0]  reg2_read_addr_i;
  logic [31:0] reg2_data_o;
  logic        stall_req_o;
  logic        init_done_o;

  int checks = 0;
  int passed = 0;

  regfile_wb_port #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .reg_write_addr_i (reg_write_addr_i),
    .reg_write_en_i   (reg_write_en_i),
    .reg_write_data_i (reg_write_data_i),
    .reg1_read_en_i   (reg1_read_en_i),
    .reg1_read_addr_i (reg1_read_addr_i),
    .reg1_data_o      (reg1_data_o),
    .reg2_read_en_i   (reg2_read_en_i),
    .reg2_read_addr_i (reg2_read_addr_i),
    .reg2_data_o      (reg2_data_o),
    .stall_req_o      (stall_req_o),
    .init_done_o      (init_done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write_en_i   = 1'b0;
    reg_write_addr_i = '0;
    reg_write_data_i = '0;
    reg1_read_en_i   = 1'b0;
    reg1_read_addr_i = '0;
    reg2_read_en_i   = 1'b0;
    reg2_read_addr_i = '0;
  endtask

  // Counts cycles with stall high after release, bounded at 100.
  task automatic count_stall(output int n);
    n = 0;
    while (stall_req_o === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    reg1_read_en_i = 1'b1; reg1_read_addr_i = 5'd4;
    reg2_read_en_i = 1'b1; reg2_read_addr_i = 5'd31;
    #1;
    checks++;
    if (stall_req_o !== 1'b1) $display("FAIL reset_stall: got %b expected 1", stall_req_o);
    else passed++;
    checks++;
    if (init_done_o !== 1'b0) $display("FAIL reset_init_done: got %b expected 0", init_done_o);
    else passed++;
    checks++;
    if (reg1_data_o !== 32'h0 || reg2_data_o !== 32'h0)
      $display("FAIL reset_reads: got %h/%h expected 0/0", reg1_data_o, reg2_data_o);
    else passed++;
    rst = 1'b0;
    count_stall(n);
    checks++;
    if (n !== 31) $display("FAIL sweep_len: got %0d cycles expected 31", n);
    else passed++;
    checks++;
    if (init_done_o !== 1'b1) $display("FAIL init_done_rise: got %b expected 1", init_done_o);
    else passed++;
    for (int i = 0; i < 32; i++) begin
      reg1_read_addr_i = 5'(i);
      reg2_read_addr_i = 5'(31 - i);
      #1;
      checks++;
      if (reg1_data_o !== 32'h0 || reg2_data_o !== 32'h0)
        $display("FAIL swept_zero r%0d: got %h/%h expected 0/0", i, reg1_data_o, reg2_data_o);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    reg_write_en_i = 1'b1; reg_write_addr_i = 5'd5; reg_write_data_i = 32'hDEADBEEF;
    reg1_read_en_i = 1'b1; reg1_read_addr_i = 5'd5;
    reg2_read_en_i = 1'b1; reg2_read_addr_i = 5'd5;
    #1;
    checks++;
    if (reg1_data_o !== 32'hDEADBEEF || reg2_data_o !== 32'hDEADBEEF)
      $display("FAIL bypass_same_cycle: got %h/%h expected deadbeef/deadbeef", reg1_data_o, reg2_data_o);
    else passed++;
    tick();
    reg_write_en_i = 1'b0; reg_write_data_i = 32'h0;
    #1;
    checks++;
    if (reg1_data_o !== 32'hDEADBEEF)
      $display("FAIL bypass_stored: got %h expected deadbeef", reg1_data_o);
    else passed++;
    // A different write address must not hijack the read.
    reg_write_en_i = 1'b1; reg_write_addr_i = 5'd6; reg_write_data_i = 32'h0BAD0BAD;
    #1;
    checks++;
    if (reg1_data_o !== 32'hDEADBEEF)
      $display("FAIL bypass_other_addr: got %h expected deadbeef", reg1_data_o);
    else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_r0();
    reg_write_en_i = 1'b1; reg_write_addr_i = 5'd0; reg_write_data_i = 32'h12345678;
    reg1_read_en_i = 1'b1; reg1_read_addr_i = 5'd0;
    reg2_read_en_i = 1'b1; reg2_read_addr_i = 5'd0;
    #1;
    checks++;
    if (reg1_data_o !== 32'h0 || reg2_data_o !== 32'h0)
      $display("FAIL r0_same_cycle: got %h/%h expected 0/0", reg1_data_o, reg2_data_o);
    else passed++;
    tick();
    reg_write_en_i = 1'b0;
    #1;
    checks++;
    if (reg1_data_o !== 32'h0 || reg2_data_o !== 32'h0)
      $display("FAIL r0_after: got %h/%h expected 0/0", reg1_data_o, reg2_data_o);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_read_en();
    reg_write_en_i = 1'b1; reg_write_addr_i = 5'd7; reg_write_data_i = 32'h11;
    tick();
    idle_inputs();
    reg1_read_en_i = 1'b0; reg1_read_addr_i = 5'd7;
    reg2_read_en_i = 1'b1; reg2_read_addr_i = 5'd7;
    #1;
    checks++;
    if (reg1_data_o !== 32'h0) $display("FAIL read_en_off: got %h expected 0", reg1_data_o);
    else passed++;
    checks++;
    if (reg2_data_o !== 32'h11) $display("FAIL read_en_on: got %h expected 11", reg2_data_o);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_mid_sweep_reset();
    int n;
    // Seed r3 so a stray INIT write or missing sweep would be visible.
    reg_write_en_i = 1'b1; reg_write_addr_i = 5'd3; reg_write_data_i = 32'h33;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reg_write_en_i = 1'b1; reg_write_addr_i = 5'd3; reg_write_data_i = 32'hFFFF;
    reg1_read_en_i = 1'b1; reg1_read_addr_i = 5'd3;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (stall_req_o !== 1'b1) $display("FAIL mid_sweep_stall: got %b expected 1", stall_req_o);
    else passed++;
    checks++;
    if (reg1_data_o !== 32'h0) $display("FAIL init_no_bypass: got %h expected 0", reg1_data_o);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_stall(n);
    checks++;
    if (n !== 31) $display("FAIL restart_sweep_len: got %0d cycles expected 31", n);
    else passed++;
    reg_write_en_i = 1'b0;
    #1;
    checks++;
    if (reg1_data_o !== 32'h0) $display("FAIL init_write_dropped: got %h expected 0", reg1_data_o);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_run_reset();
    int n;
    reg_write_en_i = 1'b1; reg_write_addr_i = 5'd9; reg_write_data_i = 32'hAA;
    tick();
    idle_inputs();
    reg2_read_en_i = 1'b1; reg2_read_addr_i = 5'd9;
    #1;
    checks++;
    if (reg2_data_o !== 32'hAA) $display("FAIL r9_written: got %h expected aa", reg2_data_o);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (stall_req_o !== 1'b1 || init_done_o !== 1'b0)
      $display("FAIL run_reset_flags: got stall=%b done=%b expected 1/0", stall_req_o, init_done_o);
    else passed++;
    count_stall(n);
    checks++;
    if (init_done_o !== 1'b1 || n !== 31)
      $display("FAIL run_reset_sweep: got done=%b after %0d expected 1 after 31", init_done_o, n);
    else passed++;
    checks++;
    if (reg2_data_o !== 32'h0) $display("FAIL r9_cleared: got %h expected 0", reg2_data_o);
    else passed++;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_bypass();
    test_r0();
    test_read_en();
    test_mid_sweep_reset();
    test_run_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
